day_3_lane_scheduler: RTL and testbench
=======================================

// Module: day_3_lane_scheduler
// PURPOSE
//  Dispatches battery-bank words from one AXI4-Stream input to NUM_LANES parallel day_3 joltage solver lanes.
//  Collects each lane's two-digit result (0..99) and accumulates the puzzle sum.
//  Emits the sum on the AXI4-Stream output once the tlast word and every in-flight line have completed.
//  Sits between the input loader and the result sink; owns all lane sequencing and occupancy.
// PARAMETERS
//  NUM_LANES    4   number of solver lanes, >=1
//  INPUTWIDTH   64  s_axis.tdata and lane_data width
//  OUTPUTWIDTH  64  accumulator and m_axis.tdata width
// PORTS
//  clk          in   1                     single clock, rising edge
//  rst_n        in   1                     asynchronous, active-low reset
//  s_axis       -    axi_stream_if.slave   bank words; tdata, tvalid, tready, tlast
//  m_axis       -    axi_stream_if.master  sum output; tdata, tvalid, tready
//  lane_start   out  NUM_LANES             1-cycle start pulse, one-hot or zero
//  lane_data    out  INPUTWIDTH            word for the started lane, broadcast to all lanes
//  lane_done    in   NUM_LANES             per-lane 1-cycle completion pulse
//  lane_result  in   NUM_LANES*7           lane i result in bits [7i+6:7i]; valid with lane_done[i]
//  err_spurious out  1                     sticky; lane_done seen on a lane that was not in flight
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=S_RUN, inflight_r=0, rr_r=0, sum=0.
//   - lane_start=0, lane_data=0, m_axis.tvalid=0, m_axis.tdata=0, err_spurious=0.
//   - s_axis.tready=0 while rst_n=0.
//   - All in-flight results are discarded; lanes share rst_n.
//  States: S_RUN, S_DRAIN, S_OUTPUT (day_3_pkg::sched_state_e).
//  S_RUN:
//   - s_axis.tready = (inflight_r != all-ones), combinational from registers only.
//   - On handshake, grant = first lane with inflight_r[i]=0, searching from rr_r upward with wrap.
//   - Next cycle: lane_start[grant]=1 and lane_data=tdata (latency 1); inflight_r[grant] set; rr_r <= (grant+1)%NUM_LANES.
//   - If tlast was set on the handshake word, go to S_DRAIN.
//  Eligibility uses registered inflight_r only: a lane freed by lane_done in cycle t becomes eligible in cycle t+1.
//  Collection (every state):
//   - Each cycle, sum += sum of lane_result[i] for all i with lane_done[i] & inflight_r[i]; simultaneous dones are all added in the same cycle.
//   - Those inflight_r bits are cleared.
//   - Arithmetic is unsigned; the sum wraps modulo 2^OUTPUTWIDTH.
//  A done with inflight_r[i]=0 is ignored for the sum and sets err_spurious (held until reset).
//  A zero tdata word is dispatched normally.
//  S_DRAIN:
//   - s_axis.tready=0.
//   - When inflight_r==0 (registered), go to S_OUTPUT; sum then includes every done.
//  S_OUTPUT:
//   - m_axis.tvalid=1 and m_axis.tdata=sum, registered.
//   - tdata is held stable while tvalid && !tready.
//   - On m_axis handshake: tvalid<=0, sum<=0, go to S_RUN; a new s_axis word can be accepted the following cycle.
//  Invariants:
//   - $onehot0(lane_start) holds.
//   - lane_start[i] is never asserted while inflight_r[i] was already set.
// STRUCTURE
//  day_3_pkg:
//   - sched_state_e.
//   - RESULT_W=7 (lane result width).
//   - Function lane_res(vec,i) extracting lane i's result.
//  Sub-module day_3_rr_pick (combinational):
//   - Inputs: free mask, pointer.
//   - Outputs: grant index and any_free.
//  Summation over lanes is a plain for-loop in the scheduler.
// TESTING
//  1. Single word 987654321111111 with tlast; lane0 done=98 after 5 cycles -> lane_start=0001 one cycle after accept; m_axis.tdata=98.
//  2. Words 987654321111111, 811111111111119, 234234234234278, 818181911112111 (last); dones in reverse order -> grants lanes 0,1,2,3; m_axis.tdata=357.
//  3. Five words with no dones -> tready low after 4th accept; done on lane 2 -> 5th word goes to lane 2 one cycle later.
//  4. All 4 lanes done in the same cycle with 98,89,78,92 -> sum rises by 357 in one cycle; S_OUTPUT emits 357.
//  5. m_axis.tready low 10 cycles -> tdata stable, s_axis.tready=0; after handshake the next file's sum starts from 0.
//  6. Done on an idle lane -> err_spurious=1 and sum unchanged; rst_n pulse mid-S_DRAIN -> all outputs return to reset values.

Source files
------------

// File: rtl/day_3_pkg.sv
// Shared types and helpers for the day_3 lane scheduler: FSM states and lane result extraction.
package day_3_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_OUTPUT = 2'd2
  } sched_state_e;

  localparam int RESULT_W  = 7;
  localparam int MAX_LANES = 64;
  localparam int RES_VEC_W = MAX_LANES * RESULT_W;

  // Callers zero-extend their packed result bus to RES_VEC_W before calling.
  function automatic logic [RESULT_W-1:0] lane_res(input logic [RES_VEC_W-1:0] vec, input int i);
    return vec[i*RESULT_W +: RESULT_W];
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI4-Stream bundle: data, valid, ready and last.
interface axi_stream_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/day_3_rr_pick.sv
// Combinational round-robin picker: first free lane at or above ptr, wrapping.
module day_3_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     free,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_free
);

  int idx;

  // Walk from the far end back toward ptr so the nearest free lane wins.
  always_comb begin
    grant    = '0;
    any_free = 1'b0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (free[idx]) begin
        grant    = IDX_W'(idx);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/day_3_lane_scheduler.sv
// Dispatches bank words to free solver lanes, sums lane results, emits one sum per tlast-terminated file.
module day_3_lane_scheduler
  import day_3_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int INPUTWIDTH  = 64,
  parameter int OUTPUTWIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axi_stream_if.slave                   s_axis,
  axi_stream_if.master                  m_axis,
  output logic [NUM_LANES-1:0]          lane_start,
  output logic [INPUTWIDTH-1:0]         lane_data,
  input  logic [NUM_LANES-1:0]          lane_done,
  input  logic [NUM_LANES*RESULT_W-1:0] lane_result,
  output logic                          err_spurious
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  sched_state_e           state_q, state_d;
  logic [NUM_LANES-1:0]   inflight_q, inflight_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [OUTPUTWIDTH-1:0] sum_q, sum_d;
  logic [NUM_LANES-1:0]   lane_start_q, lane_start_d;
  logic [INPUTWIDTH-1:0]  lane_data_q, lane_data_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [OUTPUTWIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                   err_q, err_d;

  logic [IDX_W-1:0]       grant;
  logic                   any_free;
  logic                   s_rdy;
  logic                   s_hs;
  logic [RES_VEC_W-1:0]   res_ext;
  logic [NUM_LANES-1:0]   clr;
  logic [OUTPUTWIDTH-1:0] add;

  day_3_rr_pick #(
    .N     (NUM_LANES),
    .IDX_W (IDX_W)
  ) u_pick (
    .free     (~inflight_q),
    .ptr      (rr_q),
    .grant    (grant),
    .any_free (any_free)
  );

  // Ready depends only on registered state so it never loops back through tvalid.
  assign s_rdy = rst_n && (state_q == S_RUN) && any_free;
  assign s_hs  = s_axis.tvalid && s_rdy;

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tlast  = 1'b1;
  assign lane_start    = lane_start_q;
  assign lane_data     = lane_data_q;
  assign err_spurious  = err_q;

  always_comb begin
    res_ext = '0;
    res_ext[NUM_LANES*RESULT_W-1:0] = lane_result;
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    lane_start_d = '0;
    lane_data_d  = lane_data_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    err_d        = err_q;
    clr          = '0;
    add          = '0;

    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_done[i]) begin
        if (inflight_q[i]) begin
          clr[i] = 1'b1;
          add    = add + OUTPUTWIDTH'(lane_res(res_ext, i));
        end else begin
          err_d = 1'b1;
        end
      end
    end

    sum_d      = sum_q + add;
    inflight_d = inflight_q & ~clr;

    case (state_q)
      S_RUN: begin
        if (s_hs) begin
          lane_start_d[grant] = 1'b1;
          lane_data_d         = s_axis.tdata;
          inflight_d[grant]   = 1'b1;
          rr_d = (grant == IDX_W'(NUM_LANES - 1)) ? '0 : grant + IDX_W'(1);
          if (s_axis.tlast) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once nothing is in flight every valid done has already landed in sum_q.
        if (inflight_q == '0) begin
          state_d    = S_OUTPUT;
          m_tvalid_d = 1'b1;
          m_tdata_d  = sum_q;
        end
      end
      S_OUTPUT: begin
        if (m_axis.tready) begin
          m_tvalid_d = 1'b0;
          sum_d      = '0;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      inflight_q   <= '0;
      rr_q         <= '0;
      sum_q        <= '0;
      lane_start_q <= '0;
      lane_data_q  <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      rr_q         <= rr_d;
      sum_q        <= sum_d;
      lane_start_q <= lane_start_d;
      lane_data_q  <= lane_data_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_day_3_lane_scheduler.sv
// Directed bench for day_3_lane_scheduler; the bench plays the role of the solver lanes.
module tb_day_3_lane_scheduler;

  localparam logic [63:0] W0 = 64'd987654321111111;
  localparam logic [63:0] W1 = 64'd811111111111119;
  localparam logic [63:0] W2 = 64'd234234234234278;
  localparam logic [63:0] W3 = 64'd818181911112111;
  localparam logic [63:0] W4 = 64'd123456789012345;

  logic        clk;
  logic        rst_n;
  logic [3:0]  lane_start;
  logic [63:0] lane_data;
  logic [3:0]  lane_done;
  logic [27:0] lane_result;
  logic        err_spurious;

  int checks   = 0;
  int failures = 0;

  axi_stream_if #(.DATA_W(64)) s_if ();
  axi_stream_if #(.DATA_W(64)) m_if ();

  day_3_lane_scheduler #(
    .NUM_LANES   (4),
    .INPUTWIDTH  (64),
    .OUTPUTWIDTH (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .lane_start   (lane_start),
    .lane_data    (lane_data),
    .lane_done    (lane_done),
    .lane_result  (lane_result),
    .err_spurious (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] pack(input int r0, input int r1, input int r2, input int r3);
    return {7'(r3), 7'(r2), 7'(r1), 7'(r0)};
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    lane_done   = '0;
    lane_result = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input string tag, input logic [63:0] w, input logic last, input logic [3:0] exp_start);
    int n;
    s_if.tdata  = w;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    n = 0;
    while (!s_if.tready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk({tag, "_tready_timeout"}, 64'(s_if.tready), 64'd1);
    tick();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    chk({tag, "_start"}, 64'(lane_start), 64'(exp_start));
    chk({tag, "_data"}, lane_data, w);
  endtask

  task automatic done(input logic [3:0] mask, input logic [27:0] res);
    lane_done   = mask;
    lane_result = res;
    tick();
    lane_done   = '0;
    lane_result = '0;
  endtask

  task automatic wait_out(input string tag, input logic [63:0] exp);
    int n;
    n = 0;
    while (!m_if.tvalid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_tvalid"}, 64'(m_if.tvalid), 64'd1);
    chk({tag, "_tdata"}, m_if.tdata, exp);
  endtask

  task automatic take_out(input string tag);
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    chk({tag, "_tvalid_drop"}, 64'(m_if.tvalid), 64'd0);
  endtask

  initial begin
    // Reset values, sampled while reset is still asserted
    rst_n       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    lane_done   = '0;
    lane_result = '0;
    tick();
    chk("rst_lane_start", 64'(lane_start), 64'd0);
    chk("rst_lane_data", lane_data, 64'd0);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tdata", m_if.tdata, 64'd0);
    chk("rst_err", 64'(err_spurious), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_s_tready", 64'(s_if.tready), 64'd1);

    // 1: single word, lane 0 answers 98 five cycles later
    send("t1_w0", W0, 1'b1, 4'b0001);
    tick();
    chk("t1_start_pulse_end", 64'(lane_start), 64'd0);
    chk("t1_drain_tready", 64'(s_if.tready), 64'd0);
    tick();
    tick();
    tick();
    done(4'b0001, pack(98, 0, 0, 0));
    wait_out("t1_out", 64'd98);
    take_out("t1");

    // 2: four words, dones in reverse order
    do_reset();
    send("t2_w0", W0, 1'b0, 4'b0001);
    send("t2_w1", W1, 1'b0, 4'b0010);
    send("t2_w2", W2, 1'b0, 4'b0100);
    send("t2_w3", W3, 1'b1, 4'b1000);
    done(4'b1000, pack(0, 0, 0, 92));
    done(4'b0100, pack(0, 0, 78, 0));
    chk("t2_no_early_out", 64'(m_if.tvalid), 64'd0);
    done(4'b0010, pack(0, 89, 0, 0));
    done(4'b0001, pack(98, 0, 0, 0));
    wait_out("t2_out", 64'd357);
    take_out("t2");

    // 3: all lanes busy blocks the fifth word until lane 2 frees
    do_reset();
    send("t3_w0", W0, 1'b0, 4'b0001);
    send("t3_w1", W1, 1'b0, 4'b0010);
    send("t3_w2", W2, 1'b0, 4'b0100);
    send("t3_w3", W3, 1'b0, 4'b1000);
    chk("t3_full_tready", 64'(s_if.tready), 64'd0);
    s_if.tdata  = W4;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    tick();
    tick();
    chk("t3_blocked_start", 64'(lane_start), 64'd0);
    done(4'b0100, pack(0, 0, 78, 0));
    chk("t3_freed_tready", 64'(s_if.tready), 64'd1);
    tick();
    s_if.tvalid = 1'b0;
    chk("t3_w4_start", 64'(lane_start), 64'd4);
    chk("t3_w4_data", lane_data, W4);

    // 4: all four lanes finish in the same cycle
    do_reset();
    send("t4_w0", W0, 1'b0, 4'b0001);
    send("t4_w1", W1, 1'b0, 4'b0010);
    send("t4_w2", W2, 1'b0, 4'b0100);
    send("t4_w3", W3, 1'b1, 4'b1000);
    done(4'b1111, pack(98, 89, 78, 92));
    chk("t4_tvalid_not_yet", 64'(m_if.tvalid), 64'd0);
    tick();
    chk("t4_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("t4_tdata", m_if.tdata, 64'd357);
    chk("t4_err", 64'(err_spurious), 64'd0);

    // 5: output backpressure, then the next file restarts from zero
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_tdata", m_if.tdata, 64'd357);
      chk("t5_hold_tvalid", 64'(m_if.tvalid), 64'd1);
      chk("t5_hold_s_tready", 64'(s_if.tready), 64'd0);
    end
    take_out("t5");
    chk("t5_run_tready", 64'(s_if.tready), 64'd1);
    send("t5_w0", W1, 1'b1, 4'b0001);
    tick();
    done(4'b0001, pack(5, 0, 0, 0));
    wait_out("t5_out", 64'd5);
    take_out("t5b");

    // 6: spurious done, then reset in the middle of a drain
    do_reset();
    done(4'b0010, pack(0, 50, 0, 0));
    chk("t6_err_set", 64'(err_spurious), 64'd1);
    send("t6_w0", W2, 1'b1, 4'b0001);
    done(4'b0001, pack(42, 0, 0, 0));
    wait_out("t6_out", 64'd42);
    take_out("t6");
    chk("t6_err_sticky", 64'(err_spurious), 64'd1);
    send("t6_w1", W3, 1'b0, 4'b0010);
    send("t6_w2", W4, 1'b1, 4'b0100);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_lane_start", 64'(lane_start), 64'd0);
    chk("t6_rst_lane_data", lane_data, 64'd0);
    chk("t6_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t6_rst_m_tdata", m_if.tdata, 64'd0);
    chk("t6_rst_err", 64'(err_spurious), 64'd0);
    chk("t6_rst_s_tready", 64'(s_if.tready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_rst_tready", 64'(s_if.tready), 64'd1);
    send("t6_w3", W0, 1'b1, 4'b0001);
    done(4'b0001, pack(7, 0, 0, 0));
    wait_out("t6_fresh_out", 64'd7);
    take_out("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
